// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, half-bit start qualification and
// centre-of-bit sampling, with a one-entry holding register and sticky error flags.
module uart_rx #(
   parameter int unsigned clk_freq       = 50000000,
   parameter int unsigned uart_baud_rate = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   input  logic       rx_ack,
   output logic       rx_error,
   output logic       rx_overrun
);

   localparam int unsigned D      = (clk_freq + uart_baud_rate / 2) / uart_baud_rate;
   localparam logic [15:0] C_HALF = 16'(D / 2 - 1);
   localparam logic [15:0] C_FULL = 16'(D - 1);

   typedef enum logic [2:0] {
      WAIT_HIGH,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      r_state, w_state_nx;
   logic        r_sync1, r_rxd_s;
   logic [15:0] r_cnt, w_cnt_nx;
   logic [2:0]  r_bit, w_bit_nx;
   logic [7:0]  r_shift, w_shift_nx;
   logic [7:0]  r_data, w_data_nx;
   logic        r_avail, w_avail_nx;
   logic        r_error, w_error_nx;
   logic        r_overrun, w_overrun_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1   <= 1'b0;
         r_rxd_s   <= 1'b0;
         r_state   <= WAIT_HIGH;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_avail   <= 1'b0;
         r_error   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_sync1   <= uart_rxd;
         r_rxd_s   <= r_sync1;
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_bit     <= w_bit_nx;
         r_shift   <= w_shift_nx;
         r_data    <= w_data_nx;
         r_avail   <= w_avail_nx;
         r_error   <= w_error_nx;
         r_overrun <= w_overrun_nx;
      end
   end

   // Ack clears the flags first; a delivery or framing error in the same cycle overrides it.
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt + 16'd1;
      w_bit_nx     = r_bit;
      w_shift_nx   = r_shift;
      w_data_nx    = r_data;
      w_avail_nx   = r_avail & ~rx_ack;
      w_error_nx   = r_error & ~rx_ack;
      w_overrun_nx = r_overrun & ~rx_ack;
      unique case (r_state)
         WAIT_HIGH: if (r_rxd_s) w_state_nx = IDLE;
         IDLE:      if (!r_rxd_s) w_state_nx = START;
         START: begin
            if (r_cnt == C_HALF) begin
               if (r_rxd_s) begin
                  w_state_nx = IDLE;
               end else begin
                  w_state_nx = DATA;
                  w_bit_nx   = '0;
               end
            end
         end
         DATA: begin
            if (r_cnt == C_FULL) begin
               w_cnt_nx   = '0;
               w_shift_nx = {r_rxd_s, r_shift[7:1]};
               w_bit_nx   = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_nx = STOP;
            end
         end
         STOP: begin
            if (r_cnt == C_FULL) begin
               if (r_rxd_s) begin
                  if (!r_avail || rx_ack) begin
                     w_data_nx  = r_shift;
                     w_avail_nx = 1'b1;
                  end else begin
                     w_overrun_nx = 1'b1;
                  end
                  w_state_nx = IDLE;
               end else begin
                  w_error_nx = 1'b1;
                  w_state_nx = WAIT_HIGH;
               end
            end
         end
         default: w_state_nx = WAIT_HIGH;
      endcase
      if (w_state_nx != r_state) w_cnt_nx = '0;
   end

   assign rx_data    = r_data;
   assign rx_avail   = r_avail;
   assign rx_error   = r_error;
   assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at D=43: directed table, hand-written corner sequences and
// randomized frames checked against a holding-register model.
module tb_uart_rx;

   localparam int unsigned CLK_HZ = 50000000;
   localparam int unsigned BAUD   = 1152000;
   localparam int unsigned D      = (CLK_HZ + BAUD / 2) / BAUD;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       rx_ack   = 1'b0;
   logic [7:0] rx_data;
   logic       rx_avail, rx_error, rx_overrun;

   int n_tests = 0;
   int n_fail  = 0;

   always #10 clk = ~clk;

   uart_rx #(.clk_freq(CLK_HZ), .uart_baud_rate(BAUD)) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rxd   (uart_rxd),
      .rx_data    (rx_data),
      .rx_avail   (rx_avail),
      .rx_ack     (rx_ack),
      .rx_error   (rx_error),
      .rx_overrun (rx_overrun)
   );

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       ack;
      logic [7:0] e_data;
      logic       e_avail;
      logic       e_err;
      logic       e_ovr;
   } vec_t;

   vec_t vt[6];

   function automatic logic [10:0] outs();
      return {rx_data, rx_avail, rx_error, rx_overrun};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // All stimulus tasks start and end on a falling clock edge.
   task automatic drive_bit(input logic v);
      uart_rxd = v;
      repeat (D) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   logic [7:0] m_data;
   logic       m_avail, m_err, m_ovr;
   logic [7:0] rb;
   logic       rs, ra;
   int         gap;

   initial begin
      vt[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
      vt[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vt[2] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
      vt[3] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
      vt[4] = '{8'h34, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1};
      vt[5] = '{8'h56, 1'b1, 1'b1, 8'h56, 1'b1, 1'b0, 1'b0};

      #40;
      chk("reset_hold", 32'(outs()), 32'h0);
      #40 rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("after_reset", 32'(outs()), 32'h0);

      // Single frame with exact delivery latency from the pin's falling edge.
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (410) @(negedge clk);
            chk("latency_before", 32'(rx_avail), 32'h0);
            @(negedge clk);
            chk("latency_at", 32'(outs()), 32'({8'hA5, 1'b1, 1'b0, 1'b0}));
         end
      join
      idle(2);
      pulse_ack();
      chk("ack_a5", 32'(outs()), 32'({8'hA5, 1'b0, 1'b0, 1'b0}));

      for (int i = 0; i < 6; i++) begin
         send_frame(vt[i].data, vt[i].stop);
         chk($sformatf("vec%0d", i), 32'(outs()),
             32'({vt[i].e_data, vt[i].e_avail, vt[i].e_err, vt[i].e_ovr}));
         idle(2);
         if (vt[i].ack) begin
            pulse_ack();
            chk($sformatf("vec%0d_ack", i), 32'({rx_avail, rx_error, rx_overrun}), 32'h0);
         end
      end

      // Framing error followed by a long break.
      send_frame(8'h3C, 1'b0);
      chk("frame_err", 32'(outs()), 32'({8'h56, 1'b0, 1'b1, 1'b0}));
      uart_rxd = 1'b0;
      repeat (500) @(negedge clk);
      chk("break", 32'(outs()), 32'({8'h56, 1'b0, 1'b1, 1'b0}));
      idle(20);
      send_frame(8'h81, 1'b1);
      chk("after_break", 32'(outs()), 32'({8'h81, 1'b1, 1'b1, 1'b0}));
      idle(2);
      pulse_ack();
      chk("ack_err", 32'(outs()), 32'({8'h81, 1'b0, 1'b0, 1'b0}));

      // Short low glitch must be ignored.
      uart_rxd = 1'b0;
      repeat (15) @(negedge clk);
      idle(480);
      chk("glitch", 32'(outs()), 32'({8'h81, 1'b0, 1'b0, 1'b0}));

      // Mid-frame asynchronous reset with a full holding register.
      send_frame(8'h5A, 1'b1);
      chk("pre_reset", 32'(outs()), 32'({8'h5A, 1'b1, 1'b0, 1'b0}));
      idle(3);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(rb_c3(i));
      uart_rxd = 1'b0;
      repeat (20) @(negedge clk);
      #3 rst = 1'b0;
      #1 chk("async_reset", 32'(outs()), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (100) @(negedge clk);
      chk("low_after_reset", 32'(outs()), 32'h0);
      idle(10);
      send_frame(8'h7E, 1'b1);
      chk("post_reset_rx", 32'(outs()), 32'({8'h7E, 1'b1, 1'b0, 1'b0}));
      idle(2);
      pulse_ack();

      // Ack exactly in the stop-sample cycle of the second byte.
      send_frame(8'h11, 1'b1);
      chk("coll_first", 32'(outs()), 32'({8'h11, 1'b1, 1'b0, 1'b0}));
      idle(3);
      fork
         send_frame(8'h99, 1'b1);
         begin
            repeat (410) @(negedge clk);
            pulse_ack();
         end
      join
      chk("collision", 32'(outs()), 32'({8'h99, 1'b1, 1'b0, 1'b0}));

      m_data  = 8'h99;
      m_avail = 1'b1;
      m_err   = 1'b0;
      m_ovr   = 1'b0;
      idle(4);
      for (int n = 0; n < 30; n++) begin
         rb  = 8'($urandom);
         rs  = ($urandom_range(0, 6) != 0);
         ra  = ($urandom_range(0, 2) != 0);
         gap = int'($urandom_range(4, 60));
         send_frame(rb, rs);
         if (!rs) m_err = 1'b1;
         else if (!m_avail) begin
            m_data  = rb;
            m_avail = 1'b1;
         end else m_ovr = 1'b1;
         chk($sformatf("rand%0d", n), 32'(outs()), 32'({m_data, m_avail, m_err, m_ovr}));
         idle(gap);
         if (ra) begin
            pulse_ack();
            m_avail = 1'b0;
            m_err   = 1'b0;
            m_ovr   = 1'b0;
            chk($sformatf("rand%0d_ack", n), 32'(outs()), 32'({m_data, m_avail, m_err, m_ovr}));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   function automatic logic rb_c3(input int i);
      logic [7:0] v;
      v = 8'hC3;
      return v[i];
   endfunction

endmodule
